insn_aligner: RTL and testbench
===============================

// Module: insn_aligner
// PURPOSE
// - Read side of the instruction buffer: pops 16-bit InsnBufferEntry halfwords {pc, fault, insn[15:0]}.
// - Reassembles them into whole RV32 instructions: 16-bit compressed, or 32-bit from two consecutive halfwords.
// - Presents one registered instruction per cycle to decode through a valid/ready handshake.
// - Sits between the fetch-side insn buffer and the decode stage.
// PARAMETERS
// - ADDR_WIDTH           32  PC width; must equal the width of addr_t.
// - CHECK_PC_CONTIGUITY  1   1: verify that the upper half's pc == held pc + 2. 0: no check.
// PORTS
// - clk           in   1   clock
// - rst           in   1   synchronous, active-high reset
// - flush         in   1   pipeline redirect; drops all held state
// - buf_valid     in   1   buffer head entry is valid
// - buf_entry     in   InsnBufferEntry  head entry {pc, fault, insn[15:0]}
// - buf_pop       out  1   entry consumed this cycle (combinational)
// - out_valid     out  1   out_* holds an instruction
// - out_ready     in   1   decode accepts out_* this cycle
// - out_insn      out  32  instruction; compressed form is zero-extended {16'h0, half}
// - out_pc        out  ADDR_WIDTH  pc of the first halfword
// - out_fault     out  1   fetch fault on either halfword
// - out_compressed out 1   instruction is 16-bit
// BEHAVIOUR
// - Reset or flush (flush has priority over all else):
//   - state=IDLE, out_valid=0, out_insn=0, out_pc=0, out_fault=0, out_compressed=0.
//   - Hold register cleared; buf_pop=0 in that cycle.
// - slot_free = !out_valid | out_ready. The output register loads only when slot_free=1.
// - Output latency: an entry popped in cycle N is visible on out_* in cycle N+1.
// - Output handshake: out_* stays stable while out_valid & !out_ready.
// - IDLE, buf_valid=1:
//   - If fault=1 or insn[1:0]!=2'b11: requires slot_free.
//     - Emit {16'h0, insn}; out_compressed = (insn[1:0]!=2'b11 & !fault); out_fault = fault.
//     - Pop; stay IDLE.
//   - Else (lower half of a 32-bit instruction): latch {pc, insn} into hold, pop, go to HALF.
//     - Does not need slot_free.
// - HALF, buf_valid=1:
//   - If CHECK_PC_CONTIGUITY and buf_entry.pc != hold.pc+2 (ADDR_WIDTH wrap-around arithmetic):
//     - Discard hold, go to IDLE, no pop. The entry is reprocessed next cycle.
//   - Else if slot_free:
//     - Emit {buf_entry.insn, hold.insn}, out_pc=hold.pc, out_fault=buf_entry.fault, out_compressed=0.
//     - Pop; go to IDLE.
//   - Else: stall; no pop.
// - HALF, buf_valid=0: hold is retained indefinitely.
// - Otherwise, when out_ready & out_valid and nothing new loads: out_valid -> 0.
// - Throughput:
//   - Compressed stream: one instruction per cycle.
//   - Aligned 32-bit stream: one instruction per 2 cycles (halfword-per-cycle buffer).
// CONFIGURATION
// - RAFI_RVC_EN defined: compressed decoding as above.
// - RAFI_RVC_EN undefined:
//   - A halfword with insn[1:0]!=2'b11 in IDLE is emitted with out_fault=1 and out_compressed=0.
//     Decode raises an illegal-instruction trap on it.
//   - out_compressed is tied to 0.
// TESTING
// - Reset: rst=1 for 2 cycles -> all outputs 0, buf_pop=0, state IDLE.
// - 32-bit instruction:
//   - Entries {80000000, 0, 0093} then {80000002, 0, 0010}.
//   - Cycle 3: out_insn=00100093, out_pc=80000000, out_compressed=0.
// - Compressed then 32-bit:
//   - Entries {80000000, 0, 4505}, {80000002, 0, 0513}, {80000004, 0, 0000}.
//   - Result: out 00004505 (compressed=1), then 00000513 at 80000002.
// - Back-pressure:
//   - out_ready=0 for 5 cycles with 4 compressed entries queued.
//   - out_* stays stable, buf_pop=0 after the first pop; all 4 instructions drain in order once out_ready=1.
// - Fault and flush:
//   - Upper half with fault=1 -> out_fault=1, out_pc=lower pc.
//   - flush while in HALF -> next cycle out_valid=0 and the held half is dropped.
// - Contiguity: hold pc 80000010, next entry pc 80000100 -> no pop; the entry is emitted on its own path next cycle.

Source files
------------

// File: rtl/insn_aligner.sv
// insn_aligner: reassembles 16-bit instruction-buffer halfwords into whole RV32 instructions for decode.
// Define RAFI_RVC_EN to accept compressed instructions; otherwise they are emitted flagged as faults.
package insn_aligner_pkg;
    localparam int ADDR_W = 32;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef struct packed {
        addr_t       pc;
        logic        fault;
        logic [15:0] insn;
    } insn_buffer_entry_t;
endpackage

module insn_aligner
    import insn_aligner_pkg::*;
#(
    parameter int ADDR_WIDTH          = 32,
    parameter bit CHECK_PC_CONTIGUITY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  buf_valid,
    input  insn_buffer_entry_t    buf_entry,
    output logic                  buf_pop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_insn,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_fault,
    output logic                  out_compressed
);
    // state | meaning
    // IDLE  | nothing held; the head entry starts a new instruction
    // HALF  | lower half of a 32-bit instruction held, waiting for its upper half
    typedef enum logic {IDLE, HALF} state_t;

    state_t      state;
    addr_t       hold_pc;
    logic [15:0] hold_insn;

    logic slot_free;
    logic rvc_half;
    logic full_lower;
    logic pc_break;
    logic single_fault;
    logic single_comp;

    assign slot_free  = !out_valid || out_ready;
    assign rvc_half   = buf_entry.insn[1:0] != 2'b11;
    assign full_lower = !buf_entry.fault && !rvc_half;
    assign pc_break   = CHECK_PC_CONTIGUITY && (buf_entry.pc != hold_pc + addr_t'(2));

`ifdef RAFI_RVC_EN
    assign single_fault = buf_entry.fault;
    assign single_comp  = rvc_half && !buf_entry.fault;
`else
    // Without RVC support a 16-bit encoding is illegal; decode traps on the fault flag.
    assign single_fault = buf_entry.fault || rvc_half;
    assign single_comp  = 1'b0;
`endif

    always_comb begin
        buf_pop = 1'b0;
        if (!rst && !flush && buf_valid) begin
            if (state == IDLE) begin
                buf_pop = full_lower || slot_free;
            end else begin
                buf_pop = !pc_break && slot_free;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state          <= IDLE;
            hold_pc        <= '0;
            hold_insn      <= '0;
            out_valid      <= 1'b0;
            out_insn       <= '0;
            out_pc         <= '0;
            out_fault      <= 1'b0;
            out_compressed <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (buf_valid) begin
                case (state)
                    IDLE: begin
                        if (full_lower) begin
                            hold_pc   <= buf_entry.pc;
                            hold_insn <= buf_entry.insn;
                            state     <= HALF;
                        end else if (slot_free) begin
                            out_valid      <= 1'b1;
                            out_insn       <= {16'h0000, buf_entry.insn};
                            out_pc         <= buf_entry.pc;
                            out_fault      <= single_fault;
                            out_compressed <= single_comp;
                        end
                    end
                    HALF: begin
                        // A pc gap means the held half is stale; the head entry is retried from IDLE.
                        if (pc_break) begin
                            hold_pc   <= '0;
                            hold_insn <= '0;
                            state     <= IDLE;
                        end else if (slot_free) begin
                            out_valid      <= 1'b1;
                            out_insn       <= {buf_entry.insn, hold_insn};
                            out_pc         <= hold_pc;
                            out_fault      <= buf_entry.fault;
                            out_compressed <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_insn_aligner.sv
// tb_insn_aligner: directed vector table, back-pressure sequence and randomized stream
// checked against a halfword-stream parsing model of insn_aligner.
`timescale 1ns/1ps
module tb_insn_aligner;
    import insn_aligner_pkg::*;

`ifdef RAFI_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic [31:0] pc;
        logic        fault;
        logic        comp;
    } out_t;

    typedef struct {
        logic               bv;
        insn_buffer_entry_t ent;
        logic               rdy;
        logic               fl;
        logic               exp_pop;
        out_t               exp;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               buf_valid;
    insn_buffer_entry_t buf_entry;
    logic               buf_pop;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_insn;
    logic [31:0]        out_pc;
    logic               out_fault;
    logic               out_compressed;

    int total = 0;
    int bad   = 0;

    insn_buffer_entry_t src[$];
    out_t               exp_q[$];
    out_t               got_q[$];
    vec_t               tv[$];
    logic               pop_s;
    logic               pre_rdy;
    out_t               pre;
    out_t               post;

    always #5 clk = ~clk;

    insn_aligner u_dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .buf_valid      (buf_valid),
        .buf_entry      (buf_entry),
        .buf_pop        (buf_pop),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_insn       (out_insn),
        .out_pc         (out_pc),
        .out_fault      (out_fault),
        .out_compressed (out_compressed)
    );

    function automatic out_t sample();
        return {out_valid, out_insn, out_pc, out_fault, out_compressed};
    endfunction

    function automatic insn_buffer_entry_t ent(logic [31:0] pc, logic f, logic [15:0] i);
        return {pc, f, i};
    endfunction

    function automatic out_t o(logic v, logic [31:0] i, logic [31:0] pc, logic f, logic c);
        return {v, i, pc, f, c};
    endfunction

    function automatic out_t nv(out_t x);
        out_t y;
        y = x;
        y.valid = 1'b0;
        return y;
    endfunction

    // Expected output for a halfword that forms an instruction on its own.
    function automatic out_t emit_single(insn_buffer_entry_t h);
        logic short_enc;
        short_enc = h.insn[1:0] != 2'b11;
        if (RVC) return o(1'b1, {16'h0000, h.insn}, h.pc, h.fault, short_enc && !h.fault);
        return o(1'b1, {16'h0000, h.insn}, h.pc, h.fault || short_enc, 1'b0);
    endfunction

    function automatic vec_t mk(logic bv, insn_buffer_entry_t e, logic rdy, logic fl, logic pop, out_t x);
        vec_t v;
        v.bv = bv; v.ent = e; v.rdy = rdy; v.fl = fl; v.exp_pop = pop; v.exp = x;
        return v;
    endfunction

    task automatic check_out(string name, out_t act, out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got v=%0b insn=%h pc=%h f=%0b c=%0b, want v=%0b insn=%h pc=%h f=%0b c=%0b",
                     name, act.valid, act.insn, act.pc, act.fault, act.comp,
                     exp.valid, exp.insn, exp.pc, exp.fault, exp.comp);
        end
    endtask

    task automatic check_val(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Samples the combinational pop before the edge and the registered outputs after it.
    task automatic tick();
        #1;
        pop_s   = buf_pop;
        pre     = sample();
        pre_rdy = out_ready;
        @(posedge clk);
        #1;
        post = sample();
    endtask

    task automatic present(logic allow);
        buf_valid = allow && (src.size() > 0);
        buf_entry = (src.size() > 0) ? src[0] : '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        buf_valid = 1'b1; buf_entry = ent(32'h8000_0000, 1'b0, 16'h0093);
        tick();
        check_val("reset pop c1", int'(pop_s), 0);
        tick();
        check_val("reset pop c2", int'(pop_s), 0);
        check_out("reset outputs", post, '0);
        rst = 1'b0; buf_valid = 1'b0;
    endtask

    // Parses the halfword stream by the alignment rules into the expected instruction list.
    task automatic build_expected();
        int i;
        insn_buffer_entry_t h;
        insn_buffer_entry_t u;
        i = 0;
        exp_q.delete();
        while (i < src.size()) begin
            h = src[i];
            if (h.fault || h.insn[1:0] != 2'b11) begin
                exp_q.push_back(emit_single(h));
                i++;
            end else if (i + 1 >= src.size()) begin
                i++;
            end else begin
                u = src[i+1];
                if (u.pc != h.pc + 32'd2) begin
                    i++;
                end else begin
                    exp_q.push_back(o(1'b1, {u.insn, h.insn}, h.pc, u.fault, 1'b0));
                    i += 2;
                end
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t s2, p4, p6, s9, s12, p15, s17, first;
        logic [31:0] pc;
        insn_buffer_entry_t e;
        int cyc;

        do_reset();

        // Directed vectors, applied back to back from the post-reset state.
        s2  = emit_single(ent(32'h8000_0004, 1'b0, 16'h4505));
        p4  = o(1'b1, 32'h0000_0513, 32'h8000_0006, 1'b0, 1'b0);
        p6  = o(1'b1, 32'hABCD_0003, 32'h8000_0010, 1'b1, 1'b0);
        s9  = emit_single(ent(32'h8000_0022, 1'b0, 16'h5678));
        s12 = emit_single(ent(32'h8000_0100, 1'b0, 16'h0001));
        p15 = o(1'b1, 32'h0000_0017, 32'h8000_0200, 1'b0, 1'b0);
        s17 = o(1'b1, 32'h0000_0073, 32'h8000_0300, 1'b1, 1'b0);
        tv.push_back(mk(1, ent(32'h8000_0000, 0, 16'h0093), 1, 0, 1, '0));
        tv.push_back(mk(1, ent(32'h8000_0002, 0, 16'h0010), 1, 0, 1, o(1, 32'h0010_0093, 32'h8000_0000, 0, 0)));
        tv.push_back(mk(1, ent(32'h8000_0004, 0, 16'h4505), 1, 0, 1, s2));
        tv.push_back(mk(1, ent(32'h8000_0006, 0, 16'h0513), 1, 0, 1, nv(s2)));
        tv.push_back(mk(1, ent(32'h8000_0008, 0, 16'h0000), 1, 0, 1, p4));
        tv.push_back(mk(1, ent(32'h8000_0010, 0, 16'h0003), 1, 0, 1, nv(p4)));
        tv.push_back(mk(1, ent(32'h8000_0012, 1, 16'hABCD), 1, 0, 1, p6));
        tv.push_back(mk(1, ent(32'h8000_0020, 0, 16'h1237), 0, 0, 1, p6));
        tv.push_back(mk(1, ent(32'h8000_0022, 0, 16'h5678), 0, 1, 0, '0));
        tv.push_back(mk(1, ent(32'h8000_0022, 0, 16'h5678), 1, 0, 1, s9));
        tv.push_back(mk(1, ent(32'h8000_0010, 0, 16'h0013), 1, 0, 1, nv(s9)));
        tv.push_back(mk(1, ent(32'h8000_0100, 0, 16'h0001), 1, 0, 0, nv(s9)));
        tv.push_back(mk(1, ent(32'h8000_0100, 0, 16'h0001), 1, 0, 1, s12));
        tv.push_back(mk(1, ent(32'h8000_0200, 0, 16'h0017), 0, 0, 1, s12));
        tv.push_back(mk(1, ent(32'h8000_0202, 0, 16'h0000), 0, 0, 0, s12));
        tv.push_back(mk(1, ent(32'h8000_0202, 0, 16'h0000), 1, 0, 1, p15));
        tv.push_back(mk(0, ent(32'h0000_0000, 0, 16'h0000), 1, 0, 0, nv(p15)));
        tv.push_back(mk(1, ent(32'h8000_0300, 1, 16'h0073), 1, 0, 1, s17));
        tv.push_back(mk(0, ent(32'h0000_0000, 0, 16'h0000), 0, 0, 0, s17));
        tv.push_back(mk(1, ent(32'h8000_0400, 0, 16'h0037), 1, 0, 1, nv(s17)));
        tv.push_back(mk(0, ent(32'h0000_0000, 0, 16'h0000), 1, 0, 0, nv(s17)));
        tv.push_back(mk(0, ent(32'h0000_0000, 0, 16'h0000), 1, 0, 0, nv(s17)));
        tv.push_back(mk(1, ent(32'h8000_0402, 0, 16'h1111), 1, 0, 1, o(1, 32'h1111_0037, 32'h8000_0400, 0, 0)));
        foreach (tv[k]) begin
            buf_valid = tv[k].bv; buf_entry = tv[k].ent; out_ready = tv[k].rdy; flush = tv[k].fl;
            tick();
            check_val($sformatf("vec%0d pop", k), int'(pop_s), int'(tv[k].exp_pop));
            check_out($sformatf("vec%0d out", k), post, tv[k].exp);
        end
        flush = 1'b0;

        // Back-pressure: four short instructions queued while decode stalls for five cycles.
        do_reset();
        src.delete();
        for (int k = 0; k < 4; k++) src.push_back(ent(32'h0000_0100 + 32'(2 * k), 1'b0, 16'h0011 + 16'(k * 256)));
        build_expected();
        first = exp_q[0];
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            present(1'b1);
            tick();
            if (pop_s) void'(src.pop_front());
            check_val($sformatf("bp stall pop c%0d", k), int'(pop_s), (k == 0) ? 1 : 0);
            check_out($sformatf("bp stall out c%0d", k), post, first);
        end
        out_ready = 1'b1;
        got_q.delete();
        for (int k = 0; k < 6; k++) begin
            present(1'b1);
            tick();
            if (pop_s) void'(src.pop_front());
            if (pre.valid && pre_rdy) got_q.push_back(pre);
            if (k < 3) check_val($sformatf("bp drain pop c%0d", k), int'(pop_s), 1);
        end
        check_val("bp drain count", got_q.size(), 4);
        for (int k = 0; k < 4 && k < got_q.size(); k++) check_out($sformatf("bp drain #%0d", k), got_q[k], exp_q[k]);

        // Randomized halfword stream with gaps, pc jumps, faults and random decode stalls.
        do_reset();
        src.delete();
        pc = 32'h8000_0000;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 11) == 0) pc = $urandom() & 32'hFFFF_FFFE;
            if ($urandom_range(0, 60) == 0) pc = 32'hFFFF_FFFE;
            e.pc    = pc;
            e.fault = ($urandom_range(0, 19) == 0);
            e.insn  = 16'($urandom());
            if ($urandom_range(0, 9) < 6) e.insn[1:0] = 2'b11;
            src.push_back(e);
            pc = pc + 32'd2;
        end
        build_expected();
        cyc = 0;
        while ((exp_q.size() > 0 || src.size() > 0) && cyc < 20000) begin
            present($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            cyc++;
            if (pop_s && src.size() > 0) void'(src.pop_front());
            if (pre.valid && pre_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
            if (post.valid) begin
                if (exp_q.size() > 0) begin
                    check_out($sformatf("rand c%0d", cyc), post, exp_q[0]);
                end else begin
                    check_out($sformatf("rand extra c%0d", cyc), post, '0);
                end
            end
        end
        check_val("rand leftover expected", exp_q.size(), 0);
        check_val("rand leftover entries", src.size(), 0);
        buf_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val($sformatf("rand idle valid c%0d", k), int'(post.valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
